// File: rtl/sga_matrix_render.sv
// Reader end of the snake-body RAM: on each render request it walks the RAM into a shadow
// 4x4 occupancy frame, commits it atomically, raises game flags and row-scans the LED matrix.
module sga_matrix_render #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       restart,
  input  logic       render_start,
  input  logic [3:0] size,
  input  logic [3:0] apple,
  output logic [3:0] ram_addr,
  input  logic [3:0] ram_data,
  output logic       render_busy,
  output logic       render_finish,
  output logic       maca_na_cobra,
  output logic       self_collision,
  output logic [3:0] row_sel,
  output logic [3:0] col_snake,
  output logic [3:0] col_apple,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;
  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [1:0]    state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [3:0]    last_q, last_d;
  logic [3:0]    apple_in_q, apple_in_d;
  logic          busy_q, busy_d;
  logic          finish_q, finish_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   frame_q, frame_d;
  logic [3:0]    apple_q, apple_d;
  logic          apple_vld_q, apple_vld_d;
  logic          maca_q, maca_d;
  logic          coll_q, coll_d;
  logic          acc_q, acc_d;
  logic [3:0]    head_q, head_d;
  logic          v1_q, v1_d;
  logic [3:0]    idx1_q, idx1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    row_sel_q, row_sel_d;
  logic [3:0]    col_snake_q, col_snake_d;
  logic [3:0]    col_apple_q, col_apple_d;
  logic          wrap;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_d      = last_q;
    apple_in_d  = apple_in_q;
    busy_d      = busy_q;
    finish_d    = 1'b0;
    shadow_d    = shadow_q;
    frame_d     = frame_q;
    apple_d     = apple_q;
    apple_vld_d = apple_vld_q;
    maca_d      = maca_q;
    coll_d      = coll_q;
    acc_d       = acc_q;
    head_d      = head_q;
    v1_d        = 1'b0;
    idx1_d      = addr_q;

    // v1_q marks that ram_data now holds the entry for address idx1_q.
    if (v1_q) begin
      shadow_d[ram_data] = 1'b1;
      if (idx1_q == 4'd0) head_d = ram_data;
      else if (ram_data == head_q) acc_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (render_start) begin
          state_d    = S_READ;
          shadow_d   = '0;
          addr_d     = 4'd0;
          busy_d     = 1'b1;
          acc_d      = 1'b0;
          last_d     = size - 4'd1;  // size 0 wraps to 15, i.e. 16 entries
          apple_in_d = apple;
        end
      end
      S_READ: begin
        v1_d = 1'b1;
        if (addr_q == last_q) state_d = S_DRAIN;
        else addr_d = addr_q + 4'd1;
      end
      S_DRAIN: state_d = S_COMMIT;
      default: begin
        frame_d     = shadow_q;
        apple_d     = apple_in_q;
        apple_vld_d = 1'b1;
        maca_d      = shadow_q[apple_in_q];
        coll_d      = acc_q;
        finish_d    = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    if (restart) begin
      state_d     = S_IDLE;
      addr_d      = 4'd0;
      busy_d      = 1'b0;
      finish_d    = 1'b0;
      shadow_d    = '0;
      frame_d     = '0;
      apple_d     = 4'd0;
      apple_vld_d = 1'b0;
      maca_d      = 1'b0;
      coll_d      = 1'b0;
      acc_d       = 1'b0;
      v1_d        = 1'b0;
    end

    // Column outputs are built from next-state row and frame so they never lag row_sel.
    wrap        = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d       = wrap ? '0 : cnt_q + 1'b1;
    row_d       = wrap ? row_q + 2'd1 : row_q;
    row_sel_d   = wrap ? {row_sel_q[2:0], row_sel_q[3]} : row_sel_q;
    col_snake_d = 4'(frame_d >> {row_d, 2'b00});
    col_apple_d = (apple_vld_d && apple_d[3:2] == row_d) ? (4'b0001 << apple_d[1:0]) : 4'b0000;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= 4'd0;
      last_q      <= 4'd0;
      apple_in_q  <= 4'd0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      shadow_q    <= '0;
      frame_q     <= '0;
      apple_q     <= 4'd0;
      apple_vld_q <= 1'b0;
      maca_q      <= 1'b0;
      coll_q      <= 1'b0;
      acc_q       <= 1'b0;
      head_q      <= 4'd0;
      v1_q        <= 1'b0;
      idx1_q      <= 4'd0;
      cnt_q       <= '0;
      row_q       <= 2'd0;
      row_sel_q   <= 4'b0001;
      col_snake_q <= 4'd0;
      col_apple_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      apple_in_q  <= apple_in_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      shadow_q    <= shadow_d;
      frame_q     <= frame_d;
      apple_q     <= apple_d;
      apple_vld_q <= apple_vld_d;
      maca_q      <= maca_d;
      coll_q      <= coll_d;
      acc_q       <= acc_d;
      head_q      <= head_d;
      v1_q        <= v1_d;
      idx1_q      <= idx1_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      row_sel_q   <= row_sel_d;
      col_snake_q <= col_snake_d;
      col_apple_q <= col_apple_d;
    end
  end

  assign ram_addr       = addr_q;
  assign render_busy    = busy_q;
  assign render_finish  = finish_q;
  assign maca_na_cobra  = maca_q;
  assign self_collision = coll_q;
  assign row_sel        = row_sel_q;
  assign col_snake      = col_snake_q;
  assign col_apple      = col_apple_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sga_matrix_render.sv
// Directed bench for sga_matrix_render: synchronous RAM model, hand-computed frames,
// latency, flag, busy, restart, hold and reset checks.
module tb_sga_matrix_render;

  localparam int SCAN_DIV = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       restart;
  logic       render_start;
  logic [3:0] size;
  logic [3:0] apple;
  logic [3:0] ram_addr;
  logic [3:0] ram_data;
  logic       render_busy;
  logic       render_finish;
  logic       maca_na_cobra;
  logic       self_collision;
  logic [3:0] row_sel;
  logic [3:0] col_snake;
  logic [3:0] col_apple;
  logic [1:0] dbg_state;

  logic [3:0] mem [16];
  int n_tests = 0;
  int n_fail  = 0;

  sga_matrix_render #(.SCAN_DIV(SCAN_DIV)) dut (
    .clock(clock), .reset_n(reset_n), .restart(restart), .render_start(render_start),
    .size(size), .apple(apple), .ram_addr(ram_addr), .ram_data(ram_data),
    .render_busy(render_busy), .render_finish(render_finish),
    .maca_na_cobra(maca_na_cobra), .self_collision(self_collision),
    .row_sel(row_sel), .col_snake(col_snake), .col_apple(col_apple), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // Synchronous-read snake RAM: data for an address is valid one cycle later.
  always @(posedge clock) ram_data <= mem[ram_addr];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    mem[0] = a; mem[1] = b; mem[2] = c;
  endtask

  // Issue one render and check address sequence and the finish latency of N+2 edges.
  task automatic render(input logic [3:0] sz, input logic [3:0] ap, input int n);
    int  fin_edge;
    @(negedge clock);
    size = sz; apple = ap; render_start = 1'b1;
    @(posedge clock); #1;
    render_start = 1'b0;
    check("addr_0", ram_addr, 16'd0);
    check("busy_on", render_busy, 16'd1);
    fin_edge = -1;
    for (int e = 1; e <= n + 6; e++) begin
      @(posedge clock); #1;
      if (fin_edge < 0 && e < n) check("addr_seq", ram_addr, 16'(e));
      if (fin_edge < 0 && render_finish) fin_edge = e;
      if (fin_edge >= 0) break;
    end
    if (fin_edge < 0) check("finish_timeout", 16'd0, 16'd1);
    else check("latency", 16'(fin_edge), 16'(n + 2));
    @(posedge clock); #1;
    check("finish_pulse_1cyc", render_finish, 16'd0);
    check("busy_off", render_busy, 16'd0);
  endtask

  task automatic wait_row(input int r, output logic [3:0] cs, output logic [3:0] ca);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 5 * SCAN_DIV; i++) begin
      @(posedge clock); #1;
      if (row_sel == (4'b0001 << r)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("row_timeout", 16'(row_sel), 16'(4'b0001 << r));
    cs = col_snake;
    ca = col_apple;
  endtask

  // exp_s/exp_a pack rows as {row3,row2,row1,row0}.
  task automatic check_rows(input string tag, input logic [15:0] exp_s, input logic [15:0] exp_a);
    logic [3:0] cs, ca;
    for (int r = 0; r < 4; r++) begin
      wait_row(r, cs, ca);
      check({tag, "_snake"}, cs, exp_s[r*4 +: 4]);
      check({tag, "_apple"}, ca, exp_a[r*4 +: 4]);
    end
  endtask

  initial begin
    int fin_cnt;
    reset_n = 1'b0; restart = 1'b0; render_start = 1'b0; size = 4'd0; apple = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_row_sel", row_sel, 16'h1);
    check("rst_busy", render_busy, 16'd0);
    check("rst_addr", ram_addr, 16'd0);
    check("rst_col_apple", col_apple, 16'd0);
    @(negedge clock); reset_n = 1'b1;

    // Basic render: bits 5,4,0; apple at (3,3).
    load3(4'd5, 4'd4, 4'd0);
    render(4'd3, 4'hF, 3);
    check("basic_maca", maca_na_cobra, 16'd0);
    check("basic_coll", self_collision, 16'd0);
    check_rows("basic", 16'h0031, 16'h8000);

    // Apple on snake with self collision: cells 6,7,6; apple 7.
    load3(4'd6, 4'd7, 4'd6);
    render(4'd3, 4'd7, 3);
    check("ac_maca", maca_na_cobra, 16'd1);
    check("ac_coll", self_collision, 16'd1);
    check_rows("ac", 16'h00C0, 16'h0080);

    // Apple on the final entry only, no collision.
    load3(4'd6, 4'd7, 4'd2);
    render(4'd3, 4'd2, 3);
    check("last_maca", maca_na_cobra, 16'd1);
    check("last_coll", self_collision, 16'd0);

    // Single-entry render: 3 edges.
    mem[0] = 4'd9;
    render(4'd1, 4'd0, 1);
    check("n1_maca", maca_na_cobra, 16'd0);
    check_rows("n1", 16'h0200, 16'h0001);

    // Full board via size 0.
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    render(4'd0, 4'd9, 16);
    check("full_maca", maca_na_cobra, 16'd1);
    check("full_coll", self_collision, 16'd0);
    check_rows("full", 16'hFFFF, 16'h0200);

    // render_start during READ is ignored.
    load3(4'd1, 4'd2, 4'd3);
    @(negedge clock); size = 4'd3; apple = 4'd0; render_start = 1'b1;
    @(posedge clock); #1; render_start = 1'b0;
    @(negedge clock); render_start = 1'b1;
    @(negedge clock); render_start = 1'b0;
    fin_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      if (render_finish) fin_cnt++;
    end
    check("busy_single_finish", 16'(fin_cnt), 16'd1);
    check_rows("busy", 16'h000E, 16'h0001);

    // Refill full board, then restart mid-render.
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    render(4'd0, 4'd5, 16);
    check("pre_restart_maca", maca_na_cobra, 16'd1);
    @(negedge clock); size = 4'd3; render_start = 1'b1;
    @(posedge clock); #1; render_start = 1'b0;
    @(negedge clock); restart = 1'b1;
    @(posedge clock); #1;
    check("restart_state", dbg_state, 16'd0);
    check("restart_busy", render_busy, 16'd0);
    @(negedge clock); restart = 1'b0;
    fin_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (render_finish) fin_cnt++;
    end
    check("restart_no_finish", 16'(fin_cnt), 16'd0);
    check("restart_maca", maca_na_cobra, 16'd0);
    check_rows("restart", 16'h0000, 16'h0000);

    // Frame hold: new RAM/apple without render_start change nothing.
    load3(4'd5, 4'd4, 4'd0);
    render(4'd3, 4'hF, 3);
    load3(4'd10, 4'd11, 4'd10);
    apple = 4'd10;
    check_rows("hold", 16'h0031, 16'h8000);
    check("hold_maca", maca_na_cobra, 16'd0);
    check("hold_coll", self_collision, 16'd0);

    // Asynchronous reset mid-render, then row rotation every SCAN_DIV cycles.
    @(negedge clock); size = 4'd3; render_start = 1'b1;
    @(posedge clock); #1; render_start = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("arst_busy", render_busy, 16'd0);
    check("arst_addr", ram_addr, 16'd0);
    check("arst_row_sel", row_sel, 16'h1);
    check("arst_cols", {col_snake, col_apple}, 16'h00);
    check("arst_flags", {maca_na_cobra, self_collision}, 16'd0);
    @(negedge clock); reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clock); #1;
      check("rotate", row_sel, (e < 4) ? 16'h1 : (e < 8) ? 16'h2 : 16'h4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
